uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Frame-sequencing controller for the UART receiver. It watches the serial line and the edge/bit counter status, then drives the enables of:
- the edge/bit counter
- the data sampler
- the deserializer
- the start, parity and stop checkers

It sits between the receiver top level and those datapath blocks, and reports a one-cycle data-valid or frame-error result at the end of each frame.

Parameters:
DATA_BITS, 8, data bits per frame; bit counter is 3 bits, so legal values are 1..8
PRESCALE_W, 5, width of the prescale and edge-count buses

Ports:
FSM_CLK  input  1  receiver clock, oversampling rate
FSM_RST  input  1  asynchronous active-low reset
FSM_RX_IN  input  1  serial line; idle high
FSM_PAR_EN  input  1  1 = frame carries a parity bit
FSM_prescale  input  PRESCALE_W  oversampling ratio; legal 4..31, static during a frame
FSM_edge_cnt  input  PRESCALE_W  edge count from counter
FSM_bit_cnt  input  3  bit count from counter
FSM_EdgeFinish  input  1  counter terminal count (edge_cnt == prescale)
FSM_sampled_bit  input  1  sampler majority result, valid from edge_cnt == mid+2
FSM_strt_glitch  input  1  start checker result, valid while strt_chk_en is high
FSM_par_err  input  1  parity checker result, valid while par_chk_en is high
FSM_stp_err  input  1  stop checker result, valid while stp_chk_en is high
FSM_edge_cnt_enable  output  1  edge counter enable
FSM_bit_cnt_enable  output  1  bit counter enable
FSM_dat_samp_en  output  1  sampler enable
FSM_deser_en  output  1  one-cycle shift strobe to deserializer
FSM_strt_chk_en  output  1  start checker strobe
FSM_par_chk_en  output  1  parity checker strobe
FSM_stp_chk_en  output  1  stop checker strobe
FSM_data_valid  output  1  one-cycle pulse: frame good
FSM_frame_err  output  1  one-cycle pulse: frame bad (parity or stop error)

Behaviour:
- Clock and reset:
  - Single clock FSM_CLK.
  - FSM_RST is asynchronous active-low.
  - Reset forces state IDLE, all outputs 0, and the internal error flag to 0. Reset mid-frame abandons the frame with no pulse.
- Derived values:
  - mid = FSM_prescale >> 1.
  - chk = mid + 2, the strobe edge.
- States and transitions:
  - IDLE: RX_IN == 0 -> START.
  - START:
    - At edge_cnt == chk with strt_glitch == 1 -> IDLE.
    - On EdgeFinish -> DATA.
  - DATA: EdgeFinish with bit_cnt == DATA_BITS-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: EdgeFinish -> STOP.
  - STOP: EdgeFinish -> DONE.
  - DONE, one cycle: RX_IN == 0 -> START, else -> IDLE.
- Counter and sampler enables (combinational from state):
  - edge_cnt_enable = 1 in START, DATA, PARITY, STOP. It is 0 in IDLE and DONE, so the counter clears before every frame.
  - bit_cnt_enable = 1 only in DATA. bit_cnt is 0 on entry to DATA.
  - dat_samp_en = 1 in START, DATA, PARITY, STOP.
- Strobes (combinational; exactly one cycle per bit, at edge_cnt == chk):
  - deser_en in DATA.
  - strt_chk_en in START.
  - par_chk_en in PARITY.
  - stp_chk_en in STOP.
- Error flag:
  - Cleared on entry to START.
  - Set when par_chk_en & par_err, or when stp_chk_en & stp_err.
- Result outputs (registered, asserted during DONE; latency = 1 cycle after the STOP EdgeFinish):
  - data_valid = !flag.
  - frame_err = flag.
  - Never both high; never high outside DONE.
- Boundary conditions:
  - Glitch: no valid or error pulse; the start checker is re-armed only after RX_IN returns to 0 in IDLE.
  - Back-to-back frames: RX_IN low in DONE enters START with no idle cycle.
  - Prescale below 4 is illegal; behaviour is unspecified.
  - A prescale change mid-frame is illegal.
  - A bit period spans prescale+1 clocks (edge_cnt 0..prescale).

Optional Feature:
Macro UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output FSM_break (1 bit, reset 0) and state BREAK.
  - The FSM tracks whether every sampled data bit, and the parity bit if present, was 0.
  - If that holds and the stop bit samples 0: STOP -> BREAK instead of DONE.
  - FSM_break pulses for one cycle on BREAK entry; data_valid and frame_err stay 0.
  - BREAK holds until RX_IN == 1, then goes to IDLE.
- Undefined:
  - No port and no state.
  - An all-zero frame with a low stop bit yields a frame_err pulse.

Test Plan:
- Reset-state check: hold FSM_RST low while toggling RX_IN -> all outputs 0, state IDLE. Release -> still idle until RX_IN falls.
- Good frame: prescale=8, PAR_EN=1, data 0xA5 with correct parity, stop=1 -> deser_en pulses exactly 8 times at edge_cnt==6; one par_chk_en, one stp_chk_en; data_valid high 1 cycle after the STOP EdgeFinish; frame_err 0.
- Start glitch: prescale=8, RX_IN low for 3 clocks then high, strt_glitch=1 at edge_cnt==6 -> return to IDLE, no deser_en, no result pulse.
- Parity and stop errors:
  - par_err=1 at par_chk_en -> frame_err pulse, data_valid 0.
  - PAR_EN=0 with stp_err=1 -> STOP follows 8th data bit directly; frame_err pulse.
- Back-to-back and reset: two frames with RX_IN low during DONE -> START with no idle cycle and two data_valid pulses. Assert FSM_RST mid-DATA -> immediate IDLE, enables 0, no pulse.
- Break (macro on): data 0x00, parity 0, stop 0 -> FSM_break 1 cycle; no data_valid or frame_err; stays in BREAK until RX_IN=1, then IDLE.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Status/enable bundle between the UART receive frame FSM and its datapath blocks.
// FSM_break is present only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 5
);
  logic                  FSM_RX_IN;
  logic                  FSM_PAR_EN;
  logic [PRESCALE_W-1:0] FSM_prescale;
  logic [PRESCALE_W-1:0] FSM_edge_cnt;
  logic [2:0]            FSM_bit_cnt;
  logic                  FSM_EdgeFinish;
  logic                  FSM_sampled_bit;
  logic                  FSM_strt_glitch;
  logic                  FSM_par_err;
  logic                  FSM_stp_err;
  logic                  FSM_edge_cnt_enable;
  logic                  FSM_bit_cnt_enable;
  logic                  FSM_dat_samp_en;
  logic                  FSM_deser_en;
  logic                  FSM_strt_chk_en;
  logic                  FSM_par_chk_en;
  logic                  FSM_stp_chk_en;
  logic                  FSM_data_valid;
  logic                  FSM_frame_err;
`ifdef UART_RX_BREAK_DET_EN
  logic                  FSM_break;

  modport slave (
    input  FSM_RX_IN, FSM_PAR_EN, FSM_prescale, FSM_edge_cnt, FSM_bit_cnt,
           FSM_EdgeFinish, FSM_sampled_bit, FSM_strt_glitch, FSM_par_err, FSM_stp_err,
    output FSM_edge_cnt_enable, FSM_bit_cnt_enable, FSM_dat_samp_en, FSM_deser_en,
           FSM_strt_chk_en, FSM_par_chk_en, FSM_stp_chk_en, FSM_data_valid,
           FSM_frame_err, FSM_break
  );

  modport master (
    output FSM_RX_IN, FSM_PAR_EN, FSM_prescale, FSM_edge_cnt, FSM_bit_cnt,
           FSM_EdgeFinish, FSM_sampled_bit, FSM_strt_glitch, FSM_par_err, FSM_stp_err,
    input  FSM_edge_cnt_enable, FSM_bit_cnt_enable, FSM_dat_samp_en, FSM_deser_en,
           FSM_strt_chk_en, FSM_par_chk_en, FSM_stp_chk_en, FSM_data_valid,
           FSM_frame_err, FSM_break
  );
`else
  modport slave (
    input  FSM_RX_IN, FSM_PAR_EN, FSM_prescale, FSM_edge_cnt, FSM_bit_cnt,
           FSM_EdgeFinish, FSM_sampled_bit, FSM_strt_glitch, FSM_par_err, FSM_stp_err,
    output FSM_edge_cnt_enable, FSM_bit_cnt_enable, FSM_dat_samp_en, FSM_deser_en,
           FSM_strt_chk_en, FSM_par_chk_en, FSM_stp_chk_en, FSM_data_valid,
           FSM_frame_err
  );

  modport master (
    output FSM_RX_IN, FSM_PAR_EN, FSM_prescale, FSM_edge_cnt, FSM_bit_cnt,
           FSM_EdgeFinish, FSM_sampled_bit, FSM_strt_glitch, FSM_par_err, FSM_stp_err,
    input  FSM_edge_cnt_enable, FSM_bit_cnt_enable, FSM_dat_samp_en, FSM_deser_en,
           FSM_strt_chk_en, FSM_par_chk_en, FSM_stp_chk_en, FSM_data_valid,
           FSM_frame_err
  );
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: drives counter/sampler/checker enables, pulses frame result.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | start bit, glitch check at the strobe edge
// DATA   | data bits, one deserializer shift per bit
// PARITY | parity bit check
// STOP   | stop bit check, resolves the frame at its last edge
// DONE   | one-cycle result slot
// BREAK  | all-zero frame seen, wait for line to return high
module uart_rx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int PRESCALE_W = 5
) (
  input  logic           FSM_CLK,
  input  logic           FSM_RST,
  uart_rx_fsm_if.slave   bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
`ifdef UART_RX_BREAK_DET_EN
    , BREAK
`endif
  } state_t;

  state_t state_q, state_d;
  logic   flag_q, flag_d;
  logic   data_valid_q, data_valid_d;
  logic   frame_err_q, frame_err_d;
  logic   edge_en, bit_en, samp_en, deser_en, strt_chk, par_chk, stp_chk;
  logic   stop_end, at_chk;
  logic [PRESCALE_W-1:0] chk;
`ifdef UART_RX_BREAK_DET_EN
  logic   zero_q, zero_d;
  logic   break_q, break_d;
`endif

  // strobe sits two edges past mid-bit, once the sampler majority is valid
  assign chk    = (bus.FSM_prescale >> 1) + PRESCALE_W'(2);
  assign at_chk = (bus.FSM_edge_cnt == chk);

  always_comb begin
    state_d      = state_q;
    flag_d       = flag_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    edge_en      = 1'b0;
    bit_en       = 1'b0;
    samp_en      = 1'b0;
    deser_en     = 1'b0;
    strt_chk     = 1'b0;
    par_chk      = 1'b0;
    stp_chk      = 1'b0;
    stop_end     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_d       = zero_q;
    break_d      = 1'b0;
`endif
    case (state_q)
      IDLE: if (!bus.FSM_RX_IN) begin
        state_d = START;
        flag_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_d  = 1'b1;
`endif
      end
      START: begin
        edge_en  = 1'b1;
        samp_en  = 1'b1;
        strt_chk = at_chk;
        if (at_chk && bus.FSM_strt_glitch) state_d = IDLE;
        else if (bus.FSM_EdgeFinish)       state_d = DATA;
      end
      DATA: begin
        edge_en  = 1'b1;
        bit_en   = 1'b1;
        samp_en  = 1'b1;
        deser_en = at_chk;
        if (bus.FSM_EdgeFinish && (bus.FSM_bit_cnt == LAST_BIT))
          state_d = bus.FSM_PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        edge_en = 1'b1;
        samp_en = 1'b1;
        par_chk = at_chk;
        if (bus.FSM_EdgeFinish) state_d = STOP;
      end
      STOP: begin
        edge_en  = 1'b1;
        samp_en  = 1'b1;
        stp_chk  = at_chk;
        stop_end = bus.FSM_EdgeFinish;
      end
      DONE: if (!bus.FSM_RX_IN) begin
        state_d = START;
        flag_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_d  = 1'b1;
`endif
      end else begin
        state_d = IDLE;
      end
`ifdef UART_RX_BREAK_DET_EN
      BREAK: if (bus.FSM_RX_IN) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if ((par_chk && bus.FSM_par_err) || (stp_chk && bus.FSM_stp_err)) flag_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    if ((deser_en || par_chk || stp_chk) && bus.FSM_sampled_bit) zero_d = 1'b0;
`endif

    // resolved after the flag update: with small prescale the stop strobe lands on EdgeFinish
    if (stop_end) begin
`ifdef UART_RX_BREAK_DET_EN
      if (zero_d) begin
        state_d = BREAK;
        break_d = 1'b1;
      end else begin
        state_d      = DONE;
        data_valid_d = !flag_d;
        frame_err_d  = flag_d;
      end
`else
      state_d      = DONE;
      data_valid_d = !flag_d;
      frame_err_d  = flag_d;
`endif
    end
  end

  always_ff @(posedge FSM_CLK or negedge FSM_RST) begin
    if (!FSM_RST) begin
      state_q      <= IDLE;
      flag_q       <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= 1'b0;
      break_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      flag_q       <= flag_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= zero_d;
      break_q      <= break_d;
`endif
    end
  end

  assign bus.FSM_edge_cnt_enable = edge_en;
  assign bus.FSM_bit_cnt_enable  = bit_en;
  assign bus.FSM_dat_samp_en     = samp_en;
  assign bus.FSM_deser_en        = deser_en;
  assign bus.FSM_strt_chk_en     = strt_chk;
  assign bus.FSM_par_chk_en      = par_chk;
  assign bus.FSM_stp_chk_en      = stp_chk;
  assign bus.FSM_data_valid      = data_valid_q;
  assign bus.FSM_frame_err       = frame_err_q;
`ifdef UART_RX_BREAK_DET_EN
  assign bus.FSM_break           = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: serial frames driven cycle-accurately, outcomes
// predicted from frame contents; break checks active when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_fsm;
  localparam int DB = 8;
  localparam int PW = 5;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();
  uart_rx_fsm #(.DATA_BITS(DB), .PRESCALE_W(PW)) dut (
    .FSM_CLK (clk),
    .FSM_RST (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for the edge/bit counter and an ideal sampler
  logic [PW-1:0] edge_q;
  logic [2:0]    bit_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      if (!bus.FSM_edge_cnt_enable)         edge_q <= '0;
      else if (edge_q == bus.FSM_prescale)  edge_q <= '0;
      else                                  edge_q <= edge_q + 1'b1;
      if (!bus.FSM_bit_cnt_enable)          bit_q <= '0;
      else if (edge_q == bus.FSM_prescale)  bit_q <= bit_q + 1'b1;
    end
  end
  assign bus.FSM_edge_cnt    = edge_q;
  assign bus.FSM_bit_cnt     = bit_q;
  assign bus.FSM_EdgeFinish  = (edge_q == bus.FSM_prescale);
  assign bus.FSM_sampled_bit = bus.FSM_RX_IN;

  int n_deser = 0, n_strt = 0, n_par = 0, n_stp = 0, n_dv = 0, n_fe = 0, n_brk = 0, n_both = 0;
  int deser_last = 0, par_at = 0, stp_at = 0;
  always @(negedge clk) begin
    if (bus.FSM_deser_en)    begin n_deser++; deser_last = cyc; end
    if (bus.FSM_strt_chk_en) n_strt++;
    if (bus.FSM_par_chk_en)  begin n_par++; par_at = cyc; end
    if (bus.FSM_stp_chk_en)  begin n_stp++; stp_at = cyc; end
    if (bus.FSM_data_valid)  n_dv++;
    if (bus.FSM_frame_err)   n_fe++;
    if (bus.FSM_data_valid && bus.FSM_frame_err) n_both++;
`ifdef UART_RX_BREAK_DET_EN
    if (bus.FSM_break)       n_brk++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] outs();
    logic b;
`ifdef UART_RX_BREAK_DET_EN
    b = bus.FSM_break;
`else
    b = 1'b0;
`endif
    return {bus.FSM_edge_cnt_enable, bus.FSM_bit_cnt_enable, bus.FSM_dat_samp_en,
            bus.FSM_deser_en, bus.FSM_strt_chk_en, bus.FSM_par_chk_en,
            bus.FSM_stp_chk_en, bus.FSM_data_valid, bus.FSM_frame_err, b};
  endfunction

  // Drives one frame starting in an IDLE/DONE cycle; returns in the result cycle
  // (or back in IDLE after a break), leaving the line high.
  task automatic send_frame(input logic [7:0] data, input bit pen, input bit bad_par,
                            input bit bad_stop, input int p);
    int d, nb, chk;
    bit [11:0] bits;
    bit par_bit, exp_flag, exp_brk;
    int b_deser, b_strt, b_par, b_stp, b_dv, b_fe, b_brk;
    chk      = (p >> 1) + 2;
    par_bit  = (^data) ^ bad_par;
    nb       = 2 + DB + (pen ? 1 : 0);
    bits     = '0;
    for (int i = 0; i < DB; i++) bits[1+i] = data[i];
    if (pen) bits[1+DB] = par_bit;
    bits[nb-1] = !bad_stop;
    exp_flag = (pen && bad_par) || bad_stop;
    exp_brk  = BRK_EN && (data == 8'h00) && !(pen && par_bit) && bad_stop;

    bus.FSM_PAR_EN      = pen;
    bus.FSM_prescale    = PW'(p);
    bus.FSM_par_err     = pen && bad_par;
    bus.FSM_stp_err     = bad_stop;
    bus.FSM_strt_glitch = 1'b0;
    b_deser = n_deser; b_strt = n_strt; b_par = n_par; b_stp = n_stp;
    b_dv = n_dv; b_fe = n_fe; b_brk = n_brk;
    d = cyc;
    bus.FSM_RX_IN = 1'b0;
    step();
    for (int j = 0; j < nb; j++) begin
      bus.FSM_RX_IN = bits[j];
      step(p + 1);
    end

    check("data_valid", bus.FSM_data_valid, !exp_flag && !exp_brk);
    check("frame_err",  bus.FSM_frame_err,  exp_flag && !exp_brk);
    check("dv_pulses",  n_dv - b_dv, (!exp_flag && !exp_brk) ? 1 : 0);
    check("fe_pulses",  n_fe - b_fe, (exp_flag && !exp_brk) ? 1 : 0);
    check("deser_cnt",  n_deser - b_deser, DB);
    check("deser_last", deser_last, d + 1 + DB * (p + 1) + chk);
    check("strt_cnt",   n_strt - b_strt, 1);
    check("par_cnt",    n_par - b_par, pen ? 1 : 0);
    if (pen) check("par_at", par_at, d + 1 + (DB + 1) * (p + 1) + chk);
    check("stp_cnt",    n_stp - b_stp, 1);
    check("stp_at",     stp_at, d + 1 + (nb - 1) * (p + 1) + chk);
    check("both_high",  n_both, 0);
`ifdef UART_RX_BREAK_DET_EN
    check("break",      bus.FSM_break, exp_brk);
    check("brk_pulses", n_brk - b_brk, exp_brk ? 1 : 0);
`endif
    bus.FSM_RX_IN = 1'b1;
    if (exp_brk) begin
      bus.FSM_RX_IN = 1'b0;
      step(3);
      check("break_hold", outs(), 10'h000);
      check("break_cnt1", n_brk - b_brk, 1);
      bus.FSM_RX_IN = 1'b1;
      step(2);
      check("break_exit", outs(), 10'h000);
    end
  endtask

  initial begin
    int p, gap, b_dv, b_fe, b_deser, b_strt, d;
    logic [7:0] data;
    bus.FSM_RX_IN = 1'b1;
    bus.FSM_PAR_EN = 1'b0;
    bus.FSM_prescale = PW'(8);
    bus.FSM_strt_glitch = 1'b0;
    bus.FSM_par_err = 1'b0;
    bus.FSM_stp_err = 1'b0;

    // reset held while the line toggles
    step(1);
    for (int i = 0; i < 6; i++) begin
      bus.FSM_RX_IN = ~bus.FSM_RX_IN;
      step(1);
      check("rst_outs", outs(), 10'h000);
    end
    bus.FSM_RX_IN = 1'b1;
    rst_n = 1'b1;
    step(4);
    check("idle_outs", outs(), 10'h000);

    // good frame, parity error, stop error without parity
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8);
    step(2);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 8);
    step(2);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
    step(2);

    // start glitch
    b_dv = n_dv; b_fe = n_fe; b_deser = n_deser; b_strt = n_strt;
    bus.FSM_prescale = PW'(8);
    bus.FSM_strt_glitch = 1'b1;
    d = cyc;
    bus.FSM_RX_IN = 1'b0;
    step(3);
    bus.FSM_RX_IN = 1'b1;
    step(5);
    check("glitch_idle", outs(), 10'h000);
    check("glitch_strt", n_strt - b_strt, 1);
    bus.FSM_strt_glitch = 1'b0;
    step(20);
    check("glitch_deser", n_deser - b_deser, 0);
    check("glitch_dv", n_dv - b_dv, 0);
    check("glitch_fe", n_fe - b_fe, 0);

    // back-to-back frames, no idle cycle between them
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 6);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 6);
    step(3);

    // reset in the middle of the data bits
    b_dv = n_dv; b_fe = n_fe;
    bus.FSM_prescale = PW'(8);
    bus.FSM_RX_IN = 1'b0;
    step(9 + 9 + 4);
    check("mid_data_en", bus.FSM_bit_cnt_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", outs(), 10'h000);
    step(2);
    bus.FSM_RX_IN = 1'b1;
    rst_n = 1'b1;
    step(40);
    check("rst_mid_dv", n_dv - b_dv, 0);
    check("rst_mid_fe", n_fe - b_fe, 0);
    check("rst_mid_idle", outs(), 10'h000);

    // all-zero frame with a low stop bit: break when enabled, frame error otherwise
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, 8);
    step(2);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 4);
    step(2);

    // randomized frames; prescale only changes after an idle gap
    p = $urandom_range(4, 31);
    for (int k = 0; k < 24; k++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        step(gap);
        p = $urandom_range(4, 31);
      end
      data = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send_frame(data, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), p);
    end
    step(3);
    check("final_idle", outs(), 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
